// File: rtl/unsharp_mask_engine.sv
// Unsharp-mask engine: separable KTAPS x KTAPS blur, sharpen, saturate.
// Image, kernel and result live in single-port RAMs; ap_ctrl_hs handshake.
module unsharp_mask_engine #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int PIX_BITS   = 8,
  parameter int KTAPS      = 5,
  parameter int KADDR_W    = 3,
  parameter int COEF_W     = 16,
  parameter int NORM_SHIFT = 8,
  parameter int AMT_SHIFT  = 4
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  input  logic [15:0]        amount,
  output logic [ADDR_W-1:0]  img_address0,
  output logic               img_ce0,
  input  logic [DATA_W-1:0]  img_q0,
  output logic [ADDR_W-1:0]  mask_img_address0,
  output logic               mask_img_ce0,
  output logic               mask_img_we0,
  output logic [DATA_W-1:0]  mask_img_d0,
  output logic [KADDR_W-1:0] kernelDataX_address0,
  output logic               kernelDataX_ce0,
  input  logic [DATA_W-1:0]  kernelDataX_q0,
  output logic [KADDR_W-1:0] kernelDataY_address0,
  output logic               kernelDataY_ce0,
  input  logic [DATA_W-1:0]  kernelDataY_q0
);

  localparam int R  = (KTAPS - 1) / 2;
  localparam int KW = $clog2(KTAPS + 1);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int PW = PIX_BITS + 1 + 2 * COEF_W;
  localparam int AW = PW + $clog2(KTAPS * KTAPS);
  localparam int OW = AW + 18;

  localparam logic [KW-1:0] KMAX = KW'(KTAPS - 1);
  localparam logic [KW-1:0] KNUM = KW'(KTAPS);
  localparam logic [KW-1:0] RK   = KW'(R);
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);
  localparam logic signed [OW-1:0] PMAX = OW'((1 << PIX_BITS) - 1);

  typedef enum logic [2:0] {
    IDLE, LDK, TAP, DRAIN, CALC, WRITE, DONE
  } state_t;

  state_t                    state;
  logic [KW-1:0]             kcnt, kx, ky, rkx, rky;
  logic [XW-1:0]             x;
  logic [YW-1:0]             y;
  logic                      rd_v;
  logic [15:0]               amt;
  logic signed [COEF_W-1:0]  cx [KTAPS];
  logic signed [COEF_W-1:0]  cy [KTAPS];
  logic signed [AW-1:0]      acc;
  logic [PIX_BITS-1:0]       center, res, sat;
  logic [PIX_BITS-1:0]       pix;
  logic signed [PW-1:0]      term;
  logic signed [OW-1:0]      cen_s, blur_s, prod_s, out_s;
  int                        sx, sy;
  logic                      unused;

  assign pix = img_q0[PIX_BITS-1:0];
  assign unused = ^{img_q0[DATA_W-1:PIX_BITS],
                    kernelDataX_q0[DATA_W-1:COEF_W],
                    kernelDataY_q0[DATA_W-1:COEF_W]};

  // Clamped tap coordinates for the current read
  always_comb begin
    sx = int'(x) + int'(kx) - R;
    sy = int'(y) + int'(ky) - R;
    if (sx < 0) sx = 0;
    if (sx > IMG_W - 1) sx = IMG_W - 1;
    if (sy < 0) sy = 0;
    if (sy > IMG_H - 1) sy = IMG_H - 1;
  end

  // Tap product and sharpen/saturate arithmetic
  always_comb begin
    term   = PW'($signed({1'b0, pix})) * PW'(cx[rkx]) * PW'(cy[rky]);
    cen_s  = OW'($signed({1'b0, center}));
    blur_s = OW'(acc >>> NORM_SHIFT);
    prod_s = (cen_s - blur_s) * OW'($signed({1'b0, amt}));
    out_s  = cen_s + (prod_s >>> AMT_SHIFT);
    sat    = out_s[PIX_BITS-1:0];
    if (out_s < 0) sat = '0;
    else if (out_s > PMAX) sat = '1;
  end

  assign ap_idle  = (state == IDLE);
  assign ap_done  = (state == DONE);
  assign ap_ready = (state == DONE);

  assign img_ce0      = (state == TAP);
  assign img_address0 = img_ce0 ? ADDR_W'(sy * IMG_W + sx) : '0;

  assign kernelDataX_ce0 = (state == IDLE && ap_start && !ap_rst)
                        || (state == LDK && kcnt < KNUM);
  assign kernelDataY_ce0 = kernelDataX_ce0;
  assign kernelDataX_address0 =
    (state == LDK && kcnt < KNUM) ? KADDR_W'(kcnt) : '0;
  assign kernelDataY_address0 = kernelDataX_address0;

  assign mask_img_ce0 = (state == WRITE);
  assign mask_img_we0 = (state == WRITE);
  assign mask_img_address0 =
    mask_img_ce0 ? ADDR_W'(int'(y) * IMG_W + int'(x)) : '0;
  assign mask_img_d0 = mask_img_ce0 ? DATA_W'(res) : '0;

  // Control FSM, coefficient load, tap accumulation
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= IDLE;
      kcnt   <= '0;
      kx     <= '0;
      ky     <= '0;
      rkx    <= '0;
      rky    <= '0;
      x      <= '0;
      y      <= '0;
      rd_v   <= 1'b0;
      amt    <= '0;
      acc    <= '0;
      center <= '0;
      res    <= '0;
    end else begin
      rd_v <= (state == TAP);
      rkx  <= kx;
      rky  <= ky;
      if (rd_v) begin
        acc <= acc + AW'(term);
        if (rkx == RK && rky == RK) center <= pix;
      end
      case (state)
        IDLE: if (ap_start) begin
          amt   <= amount;
          kcnt  <= KW'(1);
          x     <= '0;
          y     <= '0;
          state <= LDK;
        end
        LDK: begin
          cx[kcnt - 1'b1] <= $signed(kernelDataX_q0[COEF_W-1:0]);
          cy[kcnt - 1'b1] <= $signed(kernelDataY_q0[COEF_W-1:0]);
          kcnt <= kcnt + 1'b1;
          if (kcnt == KNUM) begin
            kx    <= '0;
            ky    <= '0;
            acc   <= '0;
            state <= TAP;
          end
        end
        TAP: begin
          if (kx == KMAX) begin
            kx <= '0;
            if (ky == KMAX) begin
              ky    <= '0;
              state <= DRAIN;
            end else begin
              ky <= ky + 1'b1;
            end
          end else begin
            kx <= kx + 1'b1;
          end
        end
        DRAIN: state <= CALC;
        CALC: begin
          res   <= sat;
          state <= WRITE;
        end
        WRITE: begin
          acc <= '0;
          if (x == XMAX) begin
            x <= '0;
            if (y == YMAX) begin
              state <= DONE;
            end else begin
              y     <= y + 1'b1;
              state <= TAP;
            end
          end else begin
            x     <= x + 1'b1;
            state <= TAP;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unsharp_mask_engine.sv
// Directed bench for unsharp_mask_engine on a 4x4 image, 3 taps.
// Two instances: NORM_SHIFT=4 (a) and NORM_SHIFT=8 (b).
module tb_unsharp_mask_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] amount = '0;
  logic        clr = 1'b0;

  logic        done_a, idle_a, ready_a, ice_a, mce_a, mwe_a, kxce_a, kyce_a;
  logic        done_b, idle_b, ready_b, ice_b, mce_b, mwe_b, kxce_b, kyce_b;
  logic [9:0]  iaddr_a, maddr_a, iaddr_b, maddr_b;
  logic [2:0]  kxaddr_a, kyaddr_a, kxaddr_b, kyaddr_b;
  logic [31:0] iq_a, md_a, kxq_a, kyq_a, iq_b, md_b, kxq_b, kyq_b;

  logic [31:0] img [16];
  logic [31:0] kxm [3];
  logic [31:0] kym [3];
  logic [31:0] outa [16];
  logic [31:0] outb [16];
  logic [9:0]  wlog_a [$];
  int          badrd_a = 0, badrd_b = 0, badwe = 0;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  unsharp_mask_engine #(
    .IMG_W(4), .IMG_H(4), .ADDR_W(10), .DATA_W(32), .PIX_BITS(8),
    .KTAPS(3), .KADDR_W(3), .COEF_W(16), .NORM_SHIFT(4), .AMT_SHIFT(4)
  ) u_a (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_a),
    .ap_done(done_a), .ap_idle(idle_a), .ap_ready(ready_a),
    .amount(amount),
    .img_address0(iaddr_a), .img_ce0(ice_a), .img_q0(iq_a),
    .mask_img_address0(maddr_a), .mask_img_ce0(mce_a),
    .mask_img_we0(mwe_a), .mask_img_d0(md_a),
    .kernelDataX_address0(kxaddr_a), .kernelDataX_ce0(kxce_a),
    .kernelDataX_q0(kxq_a),
    .kernelDataY_address0(kyaddr_a), .kernelDataY_ce0(kyce_a),
    .kernelDataY_q0(kyq_a)
  );

  unsharp_mask_engine #(
    .IMG_W(4), .IMG_H(4), .ADDR_W(10), .DATA_W(32), .PIX_BITS(8),
    .KTAPS(3), .KADDR_W(3), .COEF_W(16), .NORM_SHIFT(8), .AMT_SHIFT(4)
  ) u_b (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_b),
    .ap_done(done_b), .ap_idle(idle_b), .ap_ready(ready_b),
    .amount(amount),
    .img_address0(iaddr_b), .img_ce0(ice_b), .img_q0(iq_b),
    .mask_img_address0(maddr_b), .mask_img_ce0(mce_b),
    .mask_img_we0(mwe_b), .mask_img_d0(md_b),
    .kernelDataX_address0(kxaddr_b), .kernelDataX_ce0(kxce_b),
    .kernelDataX_q0(kxq_b),
    .kernelDataY_address0(kyaddr_b), .kernelDataY_ce0(kyce_b),
    .kernelDataY_q0(kyq_b)
  );

  // RAM models: 1-cycle read latency, write capture, write log
  always @(posedge clk) begin
    if (ice_a) begin
      iq_a <= img[iaddr_a[3:0]];
      if (iaddr_a > 10'd15) badrd_a <= badrd_a + 1;
    end
    if (ice_b) begin
      iq_b <= img[iaddr_b[3:0]];
      if (iaddr_b > 10'd15) badrd_b <= badrd_b + 1;
    end
    if (kxce_a) kxq_a <= kxm[kxaddr_a[1:0]];
    if (kyce_a) kyq_a <= kym[kyaddr_a[1:0]];
    if (kxce_b) kxq_b <= kxm[kxaddr_b[1:0]];
    if (kyce_b) kyq_b <= kym[kyaddr_b[1:0]];
    if ((mwe_a && !mce_a) || (mwe_b && !mce_b)) badwe <= badwe + 1;
    if (clr) begin
      wlog_a.delete();
      badrd_a <= 0;
      badrd_b <= 0;
      for (int i = 0; i < 16; i++) begin
        outa[i] <= 32'hDEADBEEF;
        outb[i] <= 32'hDEADBEEF;
      end
    end else begin
      if (mce_a && mwe_a) begin
        outa[maddr_a[3:0]] <= md_a;
        wlog_a.push_back(maddr_a);
      end
      if (mce_b && mwe_b) outb[maddr_b[3:0]] <= md_b;
    end
  end

  task automatic clear_logs();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic set_kernel(input int c0, input int c1, input int c2);
    kxm[0] = 32'(c0); kxm[1] = 32'(c1); kxm[2] = 32'(c2);
    kym[0] = 32'(c0); kym[1] = 32'(c1); kym[2] = 32'(c2);
  endtask

  task automatic go(input bit sel, input logic [15:0] amt);
    amount = amt;
    @(negedge clk);
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, inout int cyc,
                           output bit idle_seen, output bit hit);
    hit = 1'b0;
    idle_seen = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      cyc++;
      if (sel ? done_b : done_a) hit = 1'b1;
      else if (sel ? idle_b : idle_a) idle_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec++;
    if (idle_a !== 1'b1 || idle_b !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle: got a=%b b=%b need 1", idle_a, idle_b);
    end
    vec++;
    if ({done_a, ready_a, done_b, ready_b} !== 4'b0) begin
      bad++;
      $display("FAIL reset_done: got %b need 0000",
               {done_a, ready_a, done_b, ready_b});
    end
    vec++;
    if ({ice_a, mce_a, mwe_a, kxce_a, kyce_a} !== 5'b0) begin
      bad++;
      $display("FAIL reset_enables: got %b need 00000",
               {ice_a, mce_a, mwe_a, kxce_a, kyce_a});
    end
    vec++;
    if ({iaddr_a, maddr_a, md_a, kxaddr_a, kyaddr_a} !== 58'b0) begin
      bad++;
      $display("FAIL reset_addr_data: got %h need 0",
               {iaddr_a, maddr_a, md_a, kxaddr_a, kyaddr_a});
    end
  endtask

  task automatic test_identity();
    logic [7:0] exp [16];
    int r;
    int cyc;
    bit idl, hit;
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      exp[i] = 8'($urandom_range(0, 255));
      img[i] = {r[23:0], exp[i]};
    end
    set_kernel(0, 16, 0);
    clear_logs();
    go(1'b1, 16'd50);
    cyc = 0;
    wait_done(1'b1, cyc, idl, hit);
    vec++;
    if (!hit) begin
      bad++;
      $display("FAIL identity_done: no ap_done within %0d cycles", cyc);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (outb[i] !== {24'd0, exp[i]}) begin
        bad++;
        $display("FAIL identity_px%0d: got %h need %h",
                 i, outb[i], {24'd0, exp[i]});
      end
    end
  endtask

  task automatic test_flat();
    int cyc;
    bit idl, hit;
    for (int i = 0; i < 16; i++) img[i] = 32'd100;
    set_kernel(1, 2, 1);
    clear_logs();
    go(1'b0, 16'd64);
    cyc = 0;
    wait_done(1'b0, cyc, idl, hit);
    vec++;
    if (!hit) begin
      bad++;
      $display("FAIL flat_done: no ap_done within %0d cycles", cyc);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (outa[i] !== 32'd100) begin
        bad++;
        $display("FAIL flat_px%0d: got %0d need 100", i, outa[i]);
      end
    end
  endtask

  task automatic test_scoreboard();
    vec++;
    if (wlog_a.size() != 16) begin
      bad++;
      $display("FAIL sb_count: got %0d writes need 16", wlog_a.size());
    end
    for (int i = 0; i < 16 && i < wlog_a.size(); i++) begin
      vec++;
      if (wlog_a[i] !== 10'(i)) begin
        bad++;
        $display("FAIL sb_order%0d: got addr %0d need %0d",
                 i, wlog_a[i], i);
      end
    end
    vec++;
    if (badrd_a != 0 || badrd_b != 0 || badwe != 0) begin
      bad++;
      $display("FAIL sb_bounds: got rd_a=%0d rd_b=%0d we=%0d need 0",
               badrd_a, badrd_b, badwe);
    end
  endtask

  task automatic load_impulse();
    for (int i = 0; i < 16; i++) img[i] = 32'd0;
    img[5] = 32'd200;
    set_kernel(1, 2, 1);
  endtask

  task automatic check_impulse(input string tag);
    logic [31:0] want;
    for (int i = 0; i < 16; i++) begin
      want = (i == 5) ? 32'd255 : 32'd0;
      vec++;
      if (outa[i] !== want) begin
        bad++;
        $display("FAIL %s_px%0d: got %0d need %0d", tag, i, outa[i], want);
      end
    end
  endtask

  task automatic test_impulse();
    int cyc;
    bit idl, hit;
    load_impulse();
    clear_logs();
    go(1'b0, 16'd16);
    cyc = 0;
    wait_done(1'b0, cyc, idl, hit);
    vec++;
    if (!hit || cyc != 196) begin
      bad++;
      $display("FAIL impulse_latency: got %0d cycles need 196", cyc);
    end
    vec++;
    if (idl) begin
      bad++;
      $display("FAIL impulse_idle: got ap_idle=1 mid-frame need 0");
    end
    @(negedge clk);
    check_impulse("impulse");
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit idl, hit;
    for (int i = 0; i < 16; i++) img[i] = 32'd100;
    set_kernel(1, 2, 1);
    amount = 16'd64;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    wait_done(1'b0, cyc, idl, hit);
    vec++;
    if (!hit || {done_a, ready_a} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_pulse: got done/ready %b need 11",
               {done_a, ready_a});
    end
    @(negedge clk);
    vec++;
    if ({idle_a, done_a, ready_a} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_gap: got idle/done/ready %b need 100",
               {idle_a, done_a, ready_a});
    end
    @(posedge clk);
    #1 start_a = 1'b0;
    cyc = 0;
    wait_done(1'b0, cyc, idl, hit);
    vec++;
    if (!hit || cyc != 196 || idl) begin
      bad++;
      $display("FAIL b2b_second: got %0d cycles idle=%b need 196 idle=0",
               cyc, idl);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit idl, hit, seen;
    load_impulse();
    clear_logs();
    go(1'b0, 16'd16);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({idle_a, ice_a, mce_a, mwe_a, kxce_a} !== 5'b10000) begin
      bad++;
      $display("FAIL rst_mid: got idle/ce %b need 10000",
               {idle_a, ice_a, mce_a, mwe_a, kxce_a});
    end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ice_a || mce_a || mwe_a || kxce_a || kyce_a || done_a) seen = 1'b1;
    end
    vec++;
    if (seen) begin
      bad++;
      $display("FAIL rst_quiet: got activity after reset need none");
    end
    clear_logs();
    go(1'b0, 16'd16);
    cyc = 0;
    wait_done(1'b0, cyc, idl, hit);
    vec++;
    if (!hit || cyc != 196) begin
      bad++;
      $display("FAIL rst_rerun_latency: got %0d cycles need 196", cyc);
    end
    @(negedge clk);
    check_impulse("rerun");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) img[i] = 32'd0;
    set_kernel(0, 0, 0);
    test_reset();
    test_identity();
    test_flat();
    test_scoreboard();
    test_impulse();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
